// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and defaults for the stopwatch control path.
//   sw_state_e  : sequencer state, encoding shared with counter / HEX top
//   sw_event_e  : one decoded button event per cycle after priority
//   btn_press_t : one-cycle press pulses from the three button conditioners
package stopwatch_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 20;
  localparam int unsigned DEFAULT_MAX_COUNT = 999999;

  // Level of an idle (released) active-low button.
  localparam logic BTN_RELEASED = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  typedef enum logic [1:0] {
    EV_NONE  = 2'b00,
    EV_START = 2'b01,
    EV_STOP  = 2'b10,
    EV_LAP   = 2'b11
  } sw_event_e;

  typedef struct packed {
    logic stop;
    logic start;
    logic lap;
  } btn_press_t;

  // Same-cycle presses resolve Stop > Start > Lap; the losers are dropped.
  function automatic sw_event_e pick_event(input btn_press_t p);
    sw_event_e ev;
    ev = EV_NONE;
    if (p.stop) begin
      ev = EV_STOP;
    end else if (p.start) begin
      ev = EV_START;
    end else if (p.lap) begin
      ev = EV_LAP;
    end
    return ev;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_button_conditioner.sv
// Raw active-low push button to one-cycle press pulse.
//   Clock    : system clock
//   Reset_n  : asynchronous active-low reset
//   Button_n : raw button, asynchronous to Clock, active-low
//   Press    : registered one-cycle pulse on the debounced 1->0 transition
// After reset the conditioner stays disarmed until it has seen the button
// released for DEBOUNCE_CYCLES samples, so a button held through reset
// gives no pulse until it is released and pressed again.
module button_conditioner
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Button_n,
  output logic Press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;

  logic             target;
  logic             match;
  logic             done;

  // While disarmed we count released samples; once armed we count samples
  // that disagree with the accepted level.
  assign target = armed_q ? ~level_q : BTN_RELEASED;
  assign match  = (sync2_q == target);
  assign done   = match && (cnt_q == CNT_LAST);

  // Two-flop synchronizer, debounce counter and press pulse.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= BTN_RELEASED;
      sync2_q <= BTN_RELEASED;
      level_q <= BTN_RELEASED;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      Press   <= 1'b0;
    end else begin
      sync1_q <= Button_n;
      sync2_q <= sync1_q;
      Press   <= 1'b0;
      if (!match) begin
        cnt_q <= '0;
      end else if (done) begin
        cnt_q <= '0;
        if (armed_q) begin
          level_q <= sync2_q;
          Press   <= ~sync2_q;
        end else begin
          armed_q <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap/clear sequencer for the centisecond stopwatch counter.
//   Clock, Reset_n      : system clock, asynchronous active-low reset
//   Start_n/Stop_n/Lap_n: raw active-low buttons
//   Count               : current counter value
//   Count_En            : one-cycle increment strobe (100 Hz nominal)
//   Count_Clr           : one-cycle synchronous clear to the counter
//   Display             : value for the HEX decoders (lap value while in LAP)
//   State               : sequencer state (IDLE/RUN/PAUSE/LAP)
//   Wrapped             : sticky, counter rolled past MAX_COUNT
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned TICK_HZ         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned WIDTH           = DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT       = DEFAULT_MAX_COUNT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start_n,
  input  logic             Stop_n,
  input  logic             Lap_n,
  input  logic [WIDTH-1:0] Count,
  output logic             Count_En,
  output logic             Count_Clr,
  output logic [WIDTH-1:0] Display,
  output logic [1:0]       State,
  output logic             Wrapped
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX_COUNT);

  btn_press_t       press;
  sw_event_e        ev;
  sw_state_e        state_q;
  logic [PRE_W-1:0] prescale_q;
  logic [WIDTH-1:0] lap_q;

  logic             running;
  logic             tick;
  logic             at_max;
  logic             below_max;
  logic             illegal;
  logic             clear_from_pause;
  logic             clr_req;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Button_n (Start_n),
    .Press    (press.start)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Button_n (Stop_n),
    .Press    (press.stop)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Button_n (Lap_n),
    .Press    (press.lap)
  );

  assign ev = pick_event(press);

  // Count-rate tick and the three sources of a counter clear.
  always_comb begin
    running          = (state_q == ST_RUN) || (state_q == ST_LAP);
    tick             = running && (prescale_q == PRE_LAST);
    at_max           = (Count == MAX_VAL);
    below_max        = (Count < MAX_VAL);
    illegal          = (Count > MAX_VAL);
    clear_from_pause = (state_q == ST_PAUSE) && (ev == EV_LAP);
    clr_req          = clear_from_pause || (tick && at_max) || illegal;
  end

  assign State = state_q;

  // Sequencer, prescaler, wrap flag and display register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      prescale_q <= '0;
      lap_q      <= '0;
      Count_En   <= 1'b0;
      Count_Clr  <= 1'b0;
      Display    <= '0;
      Wrapped    <= 1'b0;
    end else begin
      // A tick at MAX_COUNT becomes a clear instead of an increment.
      Count_En  <= tick && below_max;
      Count_Clr <= clr_req;

      if (clear_from_pause) begin
        Wrapped <= 1'b0;
      end else if (tick && at_max) begin
        Wrapped <= 1'b1;
      end

      // Held in IDLE/PAUSE so a resume continues the interrupted period.
      if (clr_req) begin
        prescale_q <= '0;
      end else if (running) begin
        prescale_q <= tick ? '0 : prescale_q + PRE_W'(1);
      end

      Display <= (state_q == ST_LAP) ? lap_q : Count;

      case (state_q)
        ST_IDLE: begin
          if (ev == EV_START) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ev == EV_STOP) begin
            state_q <= ST_PAUSE;
          end else if (ev == EV_LAP) begin
            state_q <= ST_LAP;
            lap_q   <= Count;
          end
        end
        ST_LAP: begin
          if (ev == EV_STOP) begin
            state_q <= ST_PAUSE;
          end else if (ev == EV_LAP) begin
            state_q <= ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (ev == EV_START) begin
            state_q <= ST_RUN;
          end else if (ev == EV_LAP) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized bench for stopwatch_ctrl with a cycle-level behavioural model
// and a behavioural counter driving Count.
module tb_stopwatch_ctrl;

  localparam int unsigned WIDTH = 20;
  localparam int DIV  = 10;
  localparam int DEB  = 4;
  localparam int MAXC = 15;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic             Start_n;
  logic             Stop_n;
  logic             Lap_n;
  logic [WIDTH-1:0] Count;
  logic             Count_En;
  logic             Count_Clr;
  logic [WIDTH-1:0] Display;
  logic [1:0]       State;
  logic             Wrapped;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state
  int m_state;
  int m_count;
  int m_lap;
  int m_disp;
  int m_run_cycles;
  bit m_en;
  bit m_clr;
  bit m_wrap;
  int m_hist [3][6];
  bit m_level [3];
  bit m_armed [3];
  bit m_press [3];
  bit force_pending;
  int force_val;

  stopwatch_ctrl #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .DEBOUNCE_CYCLES (DEB),
    .WIDTH           (WIDTH),
    .MAX_COUNT       (MAXC)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Start_n   (Start_n),
    .Stop_n    (Stop_n),
    .Lap_n     (Lap_n),
    .Count     (Count),
    .Count_En  (Count_En),
    .Count_Clr (Count_Clr),
    .Display   (Display),
    .State     (State),
    .Wrapped   (Wrapped)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit raw_of(input int b);
    case (b)
      0:       return Start_n;
      1:       return Stop_n;
      default: return Lap_n;
    endcase
  endfunction

  // Samples taken by the two reset-valued synchronizer flops count as
  // released; older slots hold 2 (no sample yet).
  task automatic model_reset();
    m_state = S_IDLE; m_count = 0; m_lap = 0; m_disp = 0; m_run_cycles = 0;
    m_en = 0; m_clr = 0; m_wrap = 0; force_pending = 0;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 6; j++) m_hist[b][j] = (j < 2) ? 1 : 2;
      m_level[b] = 1; m_armed[b] = 0; m_press[b] = 0;
    end
    Count = '0;
  endtask

  task automatic model_step();
    int  new_count;
    bit  do_stop, do_start, do_lap, running, tick, n_en, n_clr, all1, all0;
    new_count = m_clr ? 0 : (m_en ? m_count + 1 : m_count);

    do_stop  = m_press[1];
    do_start = m_press[0] && !do_stop;
    do_lap   = m_press[2] && !do_stop && !m_press[0];

    running = (m_state == S_RUN) || (m_state == S_LAP);
    tick    = running && ((m_run_cycles % DIV) == DIV - 1);
    n_en    = tick && (m_count < MAXC);
    n_clr   = (m_state == S_PAUSE && do_lap) || (tick && m_count == MAXC) || (m_count > MAXC);

    m_disp = (m_state == S_LAP) ? m_lap : m_count;
    if (m_state == S_PAUSE && do_lap) m_wrap = 0;
    else if (tick && m_count == MAXC) m_wrap = 1;
    if (n_clr) m_run_cycles = 0;
    else if (running) m_run_cycles++;

    case (m_state)
      S_IDLE:  if (do_start) m_state = S_RUN;
      S_RUN:   if (do_stop) m_state = S_PAUSE;
               else if (do_lap) begin m_state = S_LAP; m_lap = m_count; end
      S_LAP:   if (do_stop) m_state = S_PAUSE; else if (do_lap) m_state = S_RUN;
      default: if (do_start) m_state = S_RUN; else if (do_lap) m_state = S_IDLE;
    endcase
    m_en  = n_en;
    m_clr = n_clr;

    // A level is accepted once the last DEB synchronized samples agree.
    for (int b = 0; b < 3; b++) begin
      for (int j = 5; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
      m_hist[b][0] = int'(raw_of(b));
      m_press[b] = 0;
      all1 = 1; all0 = 1;
      for (int j = 2; j < 2 + DEB; j++) begin
        if (m_hist[b][j] != 1) all1 = 0;
        if (m_hist[b][j] != 0) all0 = 0;
      end
      if (!m_armed[b]) begin
        if (all1) m_armed[b] = 1;
      end else if (m_level[b] && all0) begin
        m_level[b] = 0; m_press[b] = 1;
      end else if (!m_level[b] && all1) begin
        m_level[b] = 1;
      end
    end

    m_count = new_count;
    if (force_pending) begin
      m_count = force_val; force_pending = 0;
    end
    Count = WIDTH'(m_count);
  endtask

  task automatic cycle_step();
    @(posedge Clock);
    #1;
    if (!Reset_n) model_reset();
    else model_step();
    check_val("state",     32'(State),     32'(m_state));
    check_val("count_en",  32'(Count_En),  32'(m_en));
    check_val("count_clr", 32'(Count_Clr), 32'(m_clr));
    check_val("display",   32'(Display),   32'(m_disp));
    check_val("wrapped",   32'(Wrapped),   32'(m_wrap));
    check_val("en_clr_excl", 32'(Count_En & Count_Clr), 32'd0);
  endtask

  // mask bit0 start, bit1 stop, bit2 lap
  task automatic press(input bit [2:0] mask, input int hold, input int gap);
    if (mask[0]) Start_n = 1'b0;
    if (mask[1]) Stop_n  = 1'b0;
    if (mask[2]) Lap_n   = 1'b0;
    repeat (hold) cycle_step();
    Start_n = 1'b1; Stop_n = 1'b1; Lap_n = 1'b1;
    repeat (gap) cycle_step();
  endtask

  task automatic force_count(input int v);
    force_pending = 1;
    force_val = v;
    cycle_step();
  endtask

  initial begin
    Reset_n = 1'b0; Start_n = 1'b1; Stop_n = 1'b1; Lap_n = 1'b1;
    model_reset();
    repeat (3) cycle_step();
    Reset_n = 1'b1;

    // Idle, glitch, long hold
    repeat (50) cycle_step();
    press(3'b001, 2, 10);
    check_val("glitch_idle", 32'(State), 32'(S_IDLE));
    press(3'b001, 200, 10);
    check_val("held_start_run", 32'(State), 32'(S_RUN));
    repeat (40) cycle_step();

    // Lap freeze / release, stop, resume through a wrap
    press(3'b100, 6, 60);
    check_val("lap_state", 32'(State), 32'(S_LAP));
    press(3'b100, 6, 20);
    press(3'b010, 6, 100);
    check_val("pause_state", 32'(State), 32'(S_PAUSE));
    press(3'b001, 6, 200);
    check_val("wrapped_set", 32'(Wrapped), 32'd1);

    // Stop then lap clears back to IDLE
    press(3'b010, 6, 10);
    press(3'b100, 6, 10);
    check_val("clear_idle", 32'(State), 32'(S_IDLE));
    check_val("clear_wrapped", 32'(Wrapped), 32'd0);

    // Simultaneous start+stop from RUN, illegal count
    press(3'b001, 6, 25);
    press(3'b011, 6, 10);
    check_val("start_stop_pause", 32'(State), 32'(S_PAUSE));
    force_count(20);
    repeat (5) cycle_step();

    // Asynchronous reset mid-run with start held through it
    press(3'b001, 6, 33);
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("arst_state",   32'(State),     32'd0);
    check_val("arst_en",      32'(Count_En),  32'd0);
    check_val("arst_clr",     32'(Count_Clr), 32'd0);
    check_val("arst_display", 32'(Display),   32'd0);
    check_val("arst_wrapped", 32'(Wrapped),   32'd0);
    model_reset();
    Start_n = 1'b0;
    repeat (3) cycle_step();
    Reset_n = 1'b1;
    repeat (30) cycle_step();
    check_val("held_through_reset", 32'(State), 32'(S_IDLE));
    Start_n = 1'b1;
    repeat (10) cycle_step();
    press(3'b001, 6, 10);
    check_val("repress_run", 32'(State), 32'(S_RUN));

    // Random button traffic
    for (int it = 0; it < 400; it++) begin
      press(3'($urandom_range(1, 7)), int'($urandom_range(1, 14)), int'($urandom_range(1, 12)));
      if ($urandom_range(0, 39) == 0) force_count(MAXC + int'($urandom_range(1, 100)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 80)) cycle_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
